// File: rtl/morse_decoder.sv
// Morse code decoder: times key marks/spaces in units, classifies dots and
// dashes, looks up the finished character and shows it on a 7-seg digit.
module morse_decoder #(
    parameter int UNIT_CYCLES      = 25000000,
    parameter int DASH_UNITS       = 2,
    parameter int LETTER_GAP_UNITS = 3,
    parameter int WORD_GAP_UNITS   = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    output logic [5:0] char_code,
    output logic       char_valid,
    output logic       overflow,
    output logic [6:0] hex0
);

    localparam int PRESC_W = (UNIT_CYCLES > 2) ? $clog2(UNIT_CYCLES) : 1;
    localparam int UNIT_W  = $clog2(WORD_GAP_UNITS + 1);

    localparam logic [PRESC_W-1:0] PRESC_LAST      = PRESC_W'(UNIT_CYCLES - 1);
    localparam logic [UNIT_W-1:0]  UNITS_SAT       = UNIT_W'(WORD_GAP_UNITS);
    localparam logic [UNIT_W-1:0]  UNITS_LETTER_M1 = UNIT_W'(LETTER_GAP_UNITS - 1);
    localparam logic [UNIT_W-1:0]  UNITS_WORD_M1   = UNIT_W'(WORD_GAP_UNITS - 1);

    localparam logic [5:0] CODE_SPACE   = 6'd36;
    localparam logic [5:0] CODE_UNKNOWN = 6'd63;
    localparam logic [2:0] MAX_SYMBOLS  = 3'd5;
    localparam logic [2:0] OVF_COUNT    = 3'd6;

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        SPACE
    } state_t;

    state_t              state;
    logic [PRESC_W-1:0]  prescaler;
    logic [UNIT_W-1:0]   unit_cnt;
    logic [UNIT_W-1:0]   units_next;
    logic                unit_wrap;
    logic                key_edge;
    logic                is_dash;
    logic                letter_reached;
    logic                word_reached;
    logic [4:0]          pattern;
    logic [2:0]          sym_cnt;
    logic                word_armed;
    logic [5:0]          letter_code;

    // Map a (symbol count, pattern) pair to a character code. The first
    // keyed symbol sits in the highest used bit; dash = 1.
    function automatic logic [5:0] morse_lookup(input logic [2:0] cnt,
                                                input logic [4:0] pat);
        logic [5:0] code;
        case ({cnt, pat})
            8'b001_00000: code = 6'd14;  // E .
            8'b001_00001: code = 6'd29;  // T -
            8'b010_00000: code = 6'd18;  // I ..
            8'b010_00001: code = 6'd10;  // A .-
            8'b010_00010: code = 6'd23;  // N -.
            8'b010_00011: code = 6'd22;  // M --
            8'b011_00000: code = 6'd28;  // S ...
            8'b011_00001: code = 6'd30;  // U ..-
            8'b011_00010: code = 6'd27;  // R .-.
            8'b011_00011: code = 6'd32;  // W .--
            8'b011_00100: code = 6'd13;  // D -..
            8'b011_00101: code = 6'd20;  // K -.-
            8'b011_00110: code = 6'd16;  // G --.
            8'b011_00111: code = 6'd24;  // O ---
            8'b100_00000: code = 6'd17;  // H ....
            8'b100_00001: code = 6'd31;  // V ...-
            8'b100_00010: code = 6'd15;  // F ..-.
            8'b100_00100: code = 6'd21;  // L .-..
            8'b100_00110: code = 6'd25;  // P .--.
            8'b100_00111: code = 6'd19;  // J .---
            8'b100_01000: code = 6'd11;  // B -...
            8'b100_01001: code = 6'd33;  // X -..-
            8'b100_01010: code = 6'd12;  // C -.-.
            8'b100_01011: code = 6'd34;  // Y -.--
            8'b100_01100: code = 6'd35;  // Z --..
            8'b100_01101: code = 6'd26;  // Q --.-
            8'b101_11111: code = 6'd0;   // 0 -----
            8'b101_01111: code = 6'd1;   // 1 .----
            8'b101_00111: code = 6'd2;   // 2 ..---
            8'b101_00011: code = 6'd3;   // 3 ...--
            8'b101_00001: code = 6'd4;   // 4 ....-
            8'b101_00000: code = 6'd5;   // 5 .....
            8'b101_10000: code = 6'd6;   // 6 -....
            8'b101_11000: code = 6'd7;   // 7 --...
            8'b101_11100: code = 6'd8;   // 8 ---..
            8'b101_11110: code = 6'd9;   // 9 ----.
            default:      code = CODE_UNKNOWN;
        endcase
        return code;
    endfunction

    // Active-low glyph, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_glyph(input logic [5:0] code);
        logic [6:0] seg;
        case (code)
            6'd0:    seg = 7'b1000000;
            6'd1:    seg = 7'b1111001;
            6'd2:    seg = 7'b0100100;
            6'd3:    seg = 7'b0110000;
            6'd4:    seg = 7'b0011001;
            6'd5:    seg = 7'b0010010;
            6'd6:    seg = 7'b0000010;
            6'd7:    seg = 7'b1111000;
            6'd8:    seg = 7'b0000000;
            6'd9:    seg = 7'b0010000;
            6'd10:   seg = 7'b0001000;  // A
            6'd11:   seg = 7'b0000011;  // b
            6'd12:   seg = 7'b1000110;  // C
            6'd13:   seg = 7'b0100001;  // d
            6'd14:   seg = 7'b0000110;  // E
            6'd15:   seg = 7'b0001110;  // F
            6'd63:   seg = 7'b0111111;  // dash for unrecognised
            default: seg = 7'b1111111;  // blank
        endcase
        return seg;
    endfunction

    // Unit boundary detection and the unit count including the boundary
    // reached on this very edge, so a mark/space of N*UNIT_CYCLES cycles
    // counts as N units on the edge where it ends.
    // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        unit_wrap  = (prescaler == PRESC_LAST);
        units_next = unit_cnt;
        if (unit_wrap && (unit_cnt != UNITS_SAT)) begin
            units_next = unit_cnt + UNIT_W'(1);
        end
    end

    // The key level is implied by the state: only MARK holds the key down.
    assign key_edge       = key ^ (state == MARK);
    assign is_dash        = (int'(units_next) >= DASH_UNITS);
    assign letter_reached = unit_wrap && (unit_cnt == UNITS_LETTER_M1);
    assign word_reached   = unit_wrap && (unit_cnt == UNITS_WORD_M1);
    assign letter_code    = morse_lookup(sym_cnt, pattern);

    // Prescaler and saturating unit counter, both restarted on each key edge.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            unit_cnt  <= '0;
        end else if (key_edge) begin
            prescaler <= '0;
            unit_cnt  <= '0;
        end else begin
            prescaler <= unit_wrap ? '0 : prescaler + PRESC_W'(1);
            unit_cnt  <= units_next;
        end
    end

    // Decoder FSM with registered character outputs. The unit counter is not
    // cleared at letter emission, so the word gap is measured from the key
    // release that ended the character.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pattern    <= '0;
            sym_cnt    <= '0;
            word_armed <= 1'b0;
            char_code  <= '0;
            char_valid <= 1'b0;
            overflow   <= 1'b0;
            hex0       <= 7'b1111111;
        end else begin
            char_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (key) begin
                        state <= MARK;
                    end else if (word_armed && word_reached) begin
                        char_code  <= CODE_SPACE;
                        hex0       <= seg_glyph(CODE_SPACE);
                        char_valid <= 1'b1;
                        word_armed <= 1'b0;
                    end
                end
                MARK: begin
                    if (!key) begin
                        state <= SPACE;
                        if (sym_cnt >= MAX_SYMBOLS) begin
                            // Extra symbol is dropped; the count parks at a
                            // value the table never matches.
                            overflow <= 1'b1;
                            sym_cnt  <= OVF_COUNT;
                        end else begin
                            pattern <= {pattern[3:0], is_dash};
                            sym_cnt <= sym_cnt + 3'd1;
                        end
                    end
                end
                SPACE: begin
                    if (letter_reached) begin
                        // Emit first; a simultaneous key rise starts a fresh mark.
                        char_code  <= letter_code;
                        hex0       <= seg_glyph(letter_code);
                        char_valid <= 1'b1;
                        word_armed <= 1'b1;
                        pattern    <= '0;
                        sym_cnt    <= '0;
                        state      <= key ? MARK : IDLE;
                    end else if (key) begin
                        state <= MARK;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
